// File: rtl/decode_seq_pkg.sv
// Shared types and constants for the decode sequencer: phase encoding, trap causes
// and the retire state value.
package decode_seq_pkg;

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_EXEC   = 2'd1,
        PH_RETIRE = 2'd2,
        PH_TRAP   = 2'd3
    } phase_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_AMBIG   = 2'b11;

    localparam logic [2:0] CSTATE_RETIRE = 3'd3;

endpackage

// File: rtl/decode_sequencer_select.sv
// Classifies how many decoders claim the instruction and muxes the proposed next
// state. The mux output is only meaningful when exactly one decoder is defined.
module decode_select #(
    parameter int NDEC = 4
) (
    input  logic [NDEC-1:0]   defined_i,
    input  logic [3*NDEC-1:0] nstate_i,
    output logic              none_o,
    output logic              one_o,
    output logic              many_o,
    output logic [2:0]        nstate_o
);

    logic       seen;
    logic       multi;
    logic [2:0] mux;

    // OR-mux is sufficient because the result is only consumed in the one-hot case.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        mux   = 3'd0;
        for (int k = 0; k < NDEC; k++) begin
            if (defined_i[k]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                mux  = mux | nstate_i[3*k +: 3];
            end
        end
    end

    assign none_o   = ~seen;
    assign one_o    = seen & ~multi;
    assign many_o   = multi;
    assign nstate_o = mux;

endmodule

// File: rtl/decode_sequencer.sv
// Instruction sequencer: fetches into ir, steps cstate through the values proposed
// by the decoder bank, and raises one-cycle traps on illegal, ambiguous or timed-out fetches.
module decode_sequencer
    import decode_seq_pkg::*;
#(
    parameter int NDEC    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    output logic              ifetch_stb_o,
    input  logic              ifetch_ack_i,
    input  logic [31:0]       ifetch_dat_i,
    output logic [31:0]       ir_o,
    output logic [2:0]        cstate_o,
    output logic              ctl_en_o,
    input  logic [NDEC-1:0]   dec_defined_i,
    input  logic [3*NDEC-1:0] dec_nstate_i,
    input  logic              stall_i,
    output logic              retire_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o,
    output logic              busy_o
);

    localparam logic [7:0] FETCH_LAST = 8'(TIMEOUT - 1);

    phase_e      phase_q, phase_d;
    logic [31:0] ir_q, ir_d;
    logic [2:0]  cstate_q, cstate_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;

    logic        sel_none;
    logic        sel_one;
    logic        sel_many;
    logic [2:0]  sel_nstate;

    decode_select #(
        .NDEC (NDEC)
    ) u_select (
        .defined_i (dec_defined_i),
        .nstate_i  (dec_nstate_i),
        .none_o    (sel_none),
        .one_o     (sel_one),
        .many_o    (sel_many),
        .nstate_o  (sel_nstate)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_q  <= PH_FETCH;
            ir_q     <= 32'd0;
            cstate_q <= 3'd0;
            cnt_q    <= 8'd0;
            cause_q  <= CAUSE_NONE;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            cstate_q <= cstate_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        cstate_d = cstate_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        case (phase_q)
            PH_FETCH: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (ifetch_ack_i) begin
                    ir_d     = ifetch_dat_i;
                    cstate_d = 3'd0;
                    cnt_d    = 8'd0;
                    phase_d  = PH_EXEC;
                end else if (cnt_q == FETCH_LAST) begin
                    cnt_d   = 8'd0;
                    cause_d = CAUSE_TIMEOUT;
                    phase_d = PH_TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PH_EXEC: begin
                if (!stall_i) begin
                    if (sel_none) begin
                        cause_d = CAUSE_ILLEGAL;
                        phase_d = PH_TRAP;
                    end else if (sel_many) begin
                        cause_d = CAUSE_AMBIG;
                        phase_d = PH_TRAP;
                    end else if (sel_one) begin
                        cstate_d = sel_nstate;
                        if (sel_nstate == CSTATE_RETIRE) begin
                            phase_d = PH_RETIRE;
                        end
                    end
                end
            end
            PH_RETIRE: begin
                if (!stall_i) begin
                    cstate_d = 3'd0;
                    phase_d  = PH_FETCH;
                end
            end
            PH_TRAP: begin
                cstate_d = 3'd0;
                phase_d  = PH_FETCH;
            end
            default: begin
                phase_d = PH_FETCH;
            end
        endcase
    end

    assign ifetch_stb_o = (phase_q == PH_FETCH);
    assign busy_o       = (phase_q != PH_FETCH);
    assign ctl_en_o     = (phase_q == PH_EXEC);
    assign trap_o       = (phase_q == PH_TRAP);
    assign retire_o     = (phase_q == PH_RETIRE) && !stall_i;
    assign ir_o         = ir_q;
    assign cstate_o     = cstate_q;
    assign trap_cause_o = cause_q;

endmodule
